// File: rtl/bt656_pkg.sv
// Shared BT.656 TRS definitions: preamble codes, XYZ bit positions,
// preamble-matcher state encoding and the XYZ protection check.
package bt656_pkg;

    localparam logic [7:0] TRS_PREAMBLE_HI = 8'hFF;
    localparam logic [7:0] TRS_PREAMBLE_LO = 8'h00;

    localparam int XYZ_ONE_BIT = 7;
    localparam int XYZ_F_BIT   = 6;
    localparam int XYZ_V_BIT   = 5;
    localparam int XYZ_H_BIT   = 4;
    localparam int XYZ_P3_BIT  = 3;
    localparam int XYZ_P2_BIT  = 2;
    localparam int XYZ_P1_BIT  = 1;
    localparam int XYZ_P0_BIT  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        P3   = 2'd3
    } trs_state_t;

    // True when the fixed MSB is set and all four protection bits agree
    // with F/V/H; no correction is attempted.
    function automatic logic xyz_valid(input logic [7:0] xyz);
        logic f, v, h;
        f = xyz[XYZ_F_BIT];
        v = xyz[XYZ_V_BIT];
        h = xyz[XYZ_H_BIT];
        return xyz[XYZ_ONE_BIT]
            && (xyz[XYZ_P3_BIT] == (v ^ h))
            && (xyz[XYZ_P2_BIT] == (f ^ h))
            && (xyz[XYZ_P1_BIT] == (f ^ v))
            && (xyz[XYZ_P0_BIT] == (f ^ v ^ h));
    endfunction

endpackage

// File: rtl/bt656_xyz_check.sv
// Combinational XYZ word validation and F/V/H flag extraction.
// Kept standalone so a TRS inserter can reuse the same check.
module bt656_xyz_check
    import bt656_pkg::*;
(
    input  logic [7:0] xyz,
    output logic       valid,
    output logic       f,
    output logic       v,
    output logic       h
);

    assign valid = xyz_valid(xyz);
    assign f     = xyz[XYZ_F_BIT];
    assign v     = xyz[XYZ_V_BIT];
    assign h     = xyz[XYZ_H_BIT];

endmodule

// File: rtl/bt656_trs_decoder.sv
// BT.656 timing reference sequence decoder: finds 3FF 000 000 XYZ,
// decodes F/V/H, pulses SAV/EAV/error and measures active line length.
// Strobes land in the cycle the 3FF leaves a parallel 4-clock delay line.
module bt656_trs_decoder
    import bt656_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  sav,
    output logic                  eav,
    output logic                  trs_err,
    output logic                  field,
    output logic                  vblank,
    output logic                  hblank,
    output logic                  active,
    output logic [CNT_WIDTH-1:0]  active_len,
    output logic                  len_valid
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] TRS_OVERHEAD = CNT_WIDTH'(3);

    trs_state_t           state;
    trs_state_t           state_next;
    logic [7:0]           code;
    logic                 xyz_ok;
    logic                 xyz_f;
    logic                 xyz_v;
    logic                 xyz_h;
    logic                 good_sav;
    logic                 good_eav;
    logic                 bad_xyz;
    logic [CNT_WIDTH-1:0] cnt;

    assign code = din[DATA_WIDTH-1 -: 8];

    generate
        if (DATA_WIDTH > 8) begin : g_lsbs
            logic unused_lsbs;
            assign unused_lsbs = ^din[DATA_WIDTH-9:0];
        end
    endgenerate

    bt656_xyz_check u_xyz_check (
        .xyz   (code),
        .valid (xyz_ok),
        .f     (xyz_f),
        .v     (xyz_v),
        .h     (xyz_h)
    );

    assign good_sav = (state == P3) &&  xyz_ok && !xyz_h;
    assign good_eav = (state == P3) &&  xyz_ok &&  xyz_h;
    assign bad_xyz  = (state == P3) && !xyz_ok;

    // Preamble matcher state register; reset drops any partial match.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: an FF always (re)starts a match, zeros advance it.
    always_comb begin
        state_next = IDLE;
        if (code == TRS_PREAMBLE_HI) begin
            state_next = P1;
        end else begin
            case (state)
                P1:      if (code == TRS_PREAMBLE_LO) state_next = P2;
                P2:      if (code == TRS_PREAMBLE_LO) state_next = P3;
                default: state_next = IDLE;
            endcase
        end
    end

    // One-cycle strobes registered at the XYZ edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sav       <= 1'b0;
            eav       <= 1'b0;
            trs_err   <= 1'b0;
            len_valid <= 1'b0;
        end else begin
            sav       <= good_sav;
            eav       <= good_eav;
            trs_err   <= bad_xyz;
            len_valid <= good_eav && active;
        end
    end

    // Flags follow the last valid XYZ; active spans SAV (outside vblank) to EAV.
    always_ff @(posedge clk) begin
        if (reset) begin
            field  <= 1'b0;
            vblank <= 1'b0;
            hblank <= 1'b0;
            active <= 1'b0;
        end else begin
            if (good_sav || good_eav) begin
                field  <= xyz_f;
                vblank <= xyz_v;
                hblank <= xyz_h;
            end
            if (good_sav)      active <= !xyz_v;
            else if (good_eav) active <= 1'b0;
        end
    end

    // Active-word counter and line length; the EAV preamble words are subtracted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            active_len <= '0;
        end else begin
            if (good_sav)                    cnt <= '0;
            else if (active && cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (good_eav && active)
                active_len <= (cnt > TRS_OVERHEAD) ? cnt - TRS_OVERHEAD : '0;
        end
    end

endmodule

// File: tb/tb_bt656_trs_decoder.sv
// Self-checking bench for bt656_trs_decoder: a sliding-window reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_bt656_trs_decoder;

    localparam int DW      = 10;
    localparam int CW      = 11;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic          sav, eav, trs_err, field, vblank, hblank, active, len_valid;
    logic [CW-1:0] active_len;

    int checks = 0;
    int errors = 0;
    bit compare_en = 1'b0;

    int            hist[$];
    logic [DW-1:0] dly[$];
    bit m_sav, m_eav, m_err, m_len_valid, m_field, m_vblank, m_hblank, m_active;
    int m_cnt, m_len;

    bt656_trs_decoder #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .sav        (sav),
        .eav        (eav),
        .trs_err    (trs_err),
        .field      (field),
        .vblank     (vblank),
        .hblank     (hblank),
        .active     (active),
        .active_len (active_len),
        .len_valid  (len_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] word, input bit rst = 1'b0);
        reset = rst;
        din   = word;
        @(posedge clk);
        #1;
    endtask

    task automatic sendTrs(input logic [DW-1:0] xyz);
        applyStimulus(10'h3FF);
        applyStimulus(10'h000);
        applyStimulus(10'h000);
        applyStimulus(xyz);
    endtask

    // Reference model: an XYZ is any word that follows FF,00,00 seen since reset.
    always @(posedge clk) begin : model
        int code, f, v, h, old_cnt;
        bit ok, was_active;
        dly.push_back(din);
        if (dly.size() > 4) void'(dly.pop_front());
        m_sav = 0; m_eav = 0; m_err = 0; m_len_valid = 0;
        if (reset) begin
            m_field = 0; m_vblank = 0; m_hblank = 0; m_active = 0;
            m_cnt = 0; m_len = 0;
            hist.delete();
        end else begin
            code       = int'(din[DW-1 -: 8]);
            was_active = m_active;
            old_cnt    = m_cnt;
            if (was_active && m_cnt < CNT_MAX) m_cnt++;
            if (hist.size() == 3 && hist[0] == 255 && hist[1] == 0 && hist[2] == 0) begin
                f  = (code >> 6) & 1;
                v  = (code >> 5) & 1;
                h  = (code >> 4) & 1;
                ok = ((code >> 7) == 1) && (((code >> 3) & 1) == (v ^ h))
                  && (((code >> 2) & 1) == (f ^ h)) && (((code >> 1) & 1) == (f ^ v))
                  && ((code & 1) == (f ^ v ^ h));
                if (!ok) begin
                    m_err = 1;
                end else begin
                    m_field = f[0]; m_vblank = v[0]; m_hblank = h[0];
                    if (h == 0) begin
                        m_sav    = 1;
                        m_active = (v == 0);
                        m_cnt    = 0;
                    end else begin
                        m_eav    = 1;
                        m_active = 0;
                        if (was_active) begin
                            m_len_valid = 1;
                            m_len       = (old_cnt > 3) ? old_cnt - 3 : 0;
                        end
                    end
                end
            end
            hist.push_back(code);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    // Every-cycle comparison against the model and the parallel delay line.
    always @(negedge clk) begin
        if (compare_en) begin
            checkOutput("sav", sav, m_sav);
            checkOutput("eav", eav, m_eav);
            checkOutput("trs_err", trs_err, m_err);
            checkOutput("field", field, m_field);
            checkOutput("vblank", vblank, m_vblank);
            checkOutput("hblank", hblank, m_hblank);
            checkOutput("active", active, m_active);
            checkOutput("len_valid", len_valid, m_len_valid);
            checkOutput("active_len", active_len, m_len);
            if ((sav === 1'b1 || eav === 1'b1) && dly.size() == 4)
                checkOutput("dly_preamble", dly[0][DW-1 -: 8], 8'hFF);
        end
    end

    // Directed sequence with literal expectations at the interesting points.
    initial begin
        logic [7:0] code;
        bit f, v, h;
        reset = 1'b1;
        din   = '0;

        applyStimulus(10'h3FF, 1'b1);
        compare_en = 1'b1;
        applyStimulus(10'h000, 1'b1);
        checkOutput("rst_sav", sav, 0);
        checkOutput("rst_active", active, 0);
        checkOutput("rst_len", active_len, 0);
        checkOutput("rst_hblank", hblank, 0);

        sendTrs(10'h200);
        checkOutput("sav1_pulse", sav, 1);
        checkOutput("sav1_active", active, 1);
        checkOutput("sav1_err", trs_err, 0);
        checkOutput("sav1_field", field, 0);
        for (int i = 0; i < 1440; i++) applyStimulus(10'h200);
        checkOutput("sav1_gone", sav, 0);
        sendTrs(10'h274);
        checkOutput("eav1_pulse", eav, 1);
        checkOutput("eav1_len", active_len, 1440);
        checkOutput("eav1_lenv", len_valid, 1);
        checkOutput("eav1_active", active, 0);
        checkOutput("eav1_hblank", hblank, 1);
        applyStimulus(10'h040);
        checkOutput("eav1_lenv_off", len_valid, 0);

        sendTrs(10'h204);
        checkOutput("bad_err", trs_err, 1);
        checkOutput("bad_eav", eav, 0);
        checkOutput("bad_hblank", hblank, 1);
        checkOutput("bad_len", active_len, 1440);

        applyStimulus(10'h3FF);
        applyStimulus(10'h000);
        applyStimulus(10'h123);
        applyStimulus(10'h200);
        checkOutput("broken_sav", sav, 0);
        applyStimulus(10'h3FF);
        sendTrs(10'h2AC);
        checkOutput("vsav_pulse", sav, 1);
        checkOutput("vsav_vblank", vblank, 1);
        checkOutput("vsav_active", active, 0);

        sendTrs(10'h274);
        checkOutput("idle_eav", eav, 1);
        checkOutput("idle_lenv", len_valid, 0);

        sendTrs(10'h200);
        for (int i = 0; i < 3000; i++) applyStimulus(10'h155);
        sendTrs(10'h274);
        checkOutput("sat_len", active_len, CNT_MAX - 3);

        applyStimulus(10'h3FF);
        applyStimulus(10'h000);
        applyStimulus(10'h000);
        applyStimulus(10'h3FF);
        checkOutput("restart_err", trs_err, 1);
        applyStimulus(10'h000);
        applyStimulus(10'h000);
        applyStimulus(10'h274);
        checkOutput("restart_eav", eav, 1);

        applyStimulus(10'h3FF);
        applyStimulus(10'h000);
        applyStimulus(10'h000, 1'b1);
        applyStimulus(10'h000);
        applyStimulus(10'h200);
        checkOutput("midrst_sav", sav, 0);
        checkOutput("midrst_hblank", hblank, 0);

        for (int blk = 0; blk < 40; blk++) begin
            for (int i = 0; i < int'($urandom_range(0, 12)); i++)
                applyStimulus(DW'($urandom));
            f = 1'($urandom); v = 1'($urandom); h = 1'($urandom);
            code = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
            if ($urandom_range(0, 7) == 0) code[$urandom_range(0, 7)] ^= 1'b1;
            sendTrs({code, 2'($urandom)});
        end

        applyStimulus(10'h040);
        compare_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bt656_trs_decoder.md
Name: bt656_trs_decoder

Overview:
- Detects BT.656 timing reference sequences (3FF 000 000 XYZ) in the 10-bit parallel video word stream.
- Decodes the XYZ word into F/V/H flags and SAV/EAV strobes, and measures active-line length.
- Sits in the video parsing front end, fed by the same input word stream as delay_buffer_4clk and running in parallel with it.
- Strobes are timed so that downstream logic sees each SAV/EAV pulse in the same cycle the 3FF preamble word leaves the 4-clock delay buffer, which lets it strip or replace TRS words.

Parameters:
- DATA_WIDTH, 10, video word width; bits [DATA_WIDTH-1 -: 8] carry the 8-bit TRS code and the remaining LSBs are ignored for matching.
- CNT_WIDTH, 11, width of the active-sample counter and the active_len output.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH  video word; one word per clock, no valid qualifier.
- sav  out  1  one-cycle pulse; a valid TRS with H=0 was decoded.
- eav  out  1  one-cycle pulse; a valid TRS with H=1 was decoded.
- trs_err  out  1  one-cycle pulse; preamble matched but XYZ failed protection checks.
- field  out  1  F bit of the last valid XYZ.
- vblank  out  1  V bit of the last valid XYZ.
- hblank  out  1  H bit of the last valid XYZ.
- active  out  1  high from the cycle after sav until eav; gated by vblank=0.
- active_len  out  CNT_WIDTH  active words counted between the last SAV and the following EAV.
- len_valid  out  1  one-cycle pulse when active_len updates.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and the counter is 0. A reset mid-sequence discards the partial match.
- Matching compares the top 8 bits only: 3FF means top8=FF, 000 means top8=00.
- FSM states and transitions:
  - IDLE: FF goes to P1; anything else stays in IDLE.
  - P1: 00 goes to P2; FF stays in P1; anything else goes to IDLE.
  - P2: 00 goes to P3; FF goes to P1; anything else goes to IDLE.
  - P3: the word is taken as XYZ and decoded. The next state is IDLE, or P1 if the word is FF.
- XYZ layout: bit7=1, F=b6, V=b5, H=b4, P3=b3, P2=b2, P1=b1, P0=b0.
- XYZ is valid iff all of the following hold:
  - bit7=1
  - P3=V^H
  - P2=F^H
  - P1=F^V
  - P0=F^V^H
- No single-bit correction is performed.
- Timing: the XYZ word is sampled at edge k. sav/eav/trs_err are registered at edge k and are high for exactly the cycle following edge k. That is the same cycle in which delay_buffer_4clk outputs the 3FF word sampled at edge k-3.
- Flag updates: field/vblank/hblank update at the same edge as the strobes, only on a valid XYZ. An invalid XYZ asserts only trs_err; flags, active and the counter are unchanged.
- active: set at the sav edge when V=0; cleared at the eav edge. An SAV with V=1 leaves active at 0.
- Counter:
  - Cleared at the sav edge.
  - Increments by 1 on each clock while active=1, saturating at 2^CNT_WIDTH-1.
  - At the eav edge (active was 1), active_len is loaded with counter-3, floored at 0. This excludes the 3FF 000 000 words of the EAV, so it equals the number of words strictly between the SAV XYZ and the EAV 3FF. len_valid pulses in the same cycle.
  - An EAV while active=0 updates flags only; no len_valid.
- Back-to-back TRS: a new FF at the XYZ position restarts matching; strobes can occur as close as every 4 clocks.
- sav and eav are never high together.
- Only the flag registers and active_len hold state between strobes.

Decomposition:
- Shared package bt656_pkg:
  - TRS_PREAMBLE_HI=8'hFF, TRS_PREAMBLE_LO=8'h00.
  - XYZ bit-position constants.
  - FSM state encoding (IDLE, P1, P2, P3; 2 bits).
  - Function xyz_valid(byte) returning the protection-check result.
- One natural sub-module: bt656_xyz_check, combinational validation and F/V/H extraction. It is reusable by a future TRS inserter/scrambler re-encoder.

Test Plan:
- Reset high 2 clocks with din=3FF then 000 → all outputs 0; the first FF after reset release still starts a match.
- Stream 3FF,000,000,200 (F=0,V=0,H=0, valid) → sav=1 for exactly 1 cycle after the XYZ edge; field=vblank=hblank=0; active=1 next cycle; trs_err=0.
- SAV (200), then 1440 words of 0x200, then 3FF,000,000,274 (H=1 valid EAV) → eav pulse, active_len=1440, len_valid 1 cycle, active=0, hblank=1.
- 3FF,000,000,204 (P0 corrupted) → trs_err pulse only; flags and active_len unchanged; no sav/eav.
- Broken preamble 3FF,000,123,200 → no strobe. Then 3FF,3FF,000,000,2AC (F=0,V=1,H=0 valid) → sav pulse, vblank=1, active stays 0.
- Run parallel to delay_buffer_4clk with random data and embedded TRS → on every sav/eav cycle the buffer dout equals 3FF. Also assert reset mid-sequence after 3FF,000 → no strobe on the following 000,200.
